drp_adc_emulator: RTL and testbench

DRP_ADC_EMULATOR -- requirements
Module: drp_adc_emulator

---
 rtl/drp_adc_emulator_pkg.sv | 27 ++
 rtl/drp_adc_emulator_if.sv | 14 +
 rtl/drp_adc_emulator_regfile.sv | 105 ++++++++++
 rtl/drp_adc_emulator.sv | 135 +++++++++++++
 tb/tb_drp_adc_emulator.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/drp_adc_emulator_pkg.sv
// Shared types and constants for the DRP ADC emulator: conversion FSM states,
// DRP register addresses, default timing and the 4-sample averaging helper.
package drp_adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } conv_state_e;

    localparam logic [6:0] ADDR_RESULT = 7'h00;
    localparam logic [6:0] ADDR_CFG0   = 7'h40;
    localparam logic [6:0] ADDR_CFG1   = 7'h41;
    localparam logic [6:0] ADDR_CFG2   = 7'h42;

    localparam int DEF_CONV_CYCLES = 26;
    localparam int DEF_DRP_LAT     = 2;

    // Floor of the mean of four 12-bit samples; the 14-bit sum cannot overflow.
    function automatic logic [11:0] avg4(input logic [11:0] a, input logic [11:0] b,
                                         input logic [11:0] c, input logic [11:0] d);
        logic [13:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[13:2];
    endfunction

endpackage

// File: rtl/drp_adc_emulator_if.sv
// DRP bus between an initiator (master) and the ADC emulator (slave).
interface drp_adc_emulator_if;
    logic [6:0]  DAddr;
    logic        DEn;
    logic        DWe;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DRdy;

    modport master (output DAddr, output DEn, output DWe, output DI,
                    input  DO,    input  DRdy);
    modport slave  (input  DAddr, input  DEn, input  DWe, input  DI,
                    output DO,    output DRdy);
endinterface

// File: rtl/drp_adc_emulator_regfile.sv
// DRP register map, single-outstanding access acceptance and the fixed-latency
// response pipeline of the ADC emulator.
module drp_adc_regfile
    import drp_adc_pkg::*;
#(
    parameter int DRP_LAT = DEF_DRP_LAT
) (
    input  logic               AdcClk,
    input  logic               AdcRstN,
    drp_adc_emulator_if.slave  drp,
    input  logic               res_we_i,
    input  logic [15:0]        res_data_i
);

    localparam logic [3:0] LAT_INIT = (DRP_LAT > 1) ? 4'(DRP_LAT - 2) : 4'd0;

    logic [15:0] result_q;
    logic [15:0] cfg0_q;
    logic [15:0] cfg1_q;
    logic [15:0] cfg2_q;
    logic        pend_q;
    logic [3:0]  lat_q;
    logic [15:0] hold_q;
    logic        drdy_q;
    logic [15:0] do_q;
    logic        accept_s;
    logic [15:0] rd_s;
    logic [15:0] cap_s;

    // Read mux; the result entry forwards the value being committed this cycle.
    always_comb begin
        rd_s = 16'h0000;
        case (drp.DAddr)
            ADDR_RESULT: rd_s = res_we_i ? res_data_i : result_q;
            ADDR_CFG0:   rd_s = cfg0_q;
            ADDR_CFG1:   rd_s = cfg1_q;
            ADDR_CFG2:   rd_s = cfg2_q;
            default:     rd_s = 16'h0000;
        endcase
    end

    // Accept qualification and the response word captured on the accept cycle.
    always_comb begin
        accept_s = drp.DEn && !pend_q;
        cap_s    = drp.DWe ? 16'h0000 : rd_s;
    end

    // Register storage: result from the converter, config words from DRP writes.
    always_ff @(posedge AdcClk) begin
        if (!AdcRstN) begin
            result_q <= 16'h0000;
            cfg0_q   <= 16'h0000;
            cfg1_q   <= 16'h0000;
            cfg2_q   <= 16'h0000;
        end else begin
            if (res_we_i) begin
                result_q <= res_data_i;
            end
            if (accept_s && drp.DWe) begin
                case (drp.DAddr)
                    ADDR_CFG0: cfg0_q <= drp.DI;
                    ADDR_CFG1: cfg1_q <= drp.DI;
                    ADDR_CFG2: cfg2_q <= drp.DI;
                    default:   ;
                endcase
            end
        end
    end

    // Response pipeline: one access in flight, DRdy/DO driven for a single cycle.
    always_ff @(posedge AdcClk) begin
        if (!AdcRstN) begin
            pend_q <= 1'b0;
            lat_q  <= 4'd0;
            hold_q <= 16'h0000;
            drdy_q <= 1'b0;
            do_q   <= 16'h0000;
        end else begin
            drdy_q <= 1'b0;
            do_q   <= 16'h0000;
            if (pend_q) begin
                if (lat_q == 4'd0) begin
                    pend_q <= 1'b0;
                    drdy_q <= 1'b1;
                    do_q   <= hold_q;
                end else begin
                    lat_q <= lat_q - 4'd1;
                end
            end else if (accept_s) begin
                if (DRP_LAT <= 1) begin
                    drdy_q <= 1'b1;
                    do_q   <= cap_s;
                end else begin
                    pend_q <= 1'b1;
                    lat_q  <= LAT_INIT;
                    hold_q <= cap_s;
                end
            end
        end
    end

    assign drp.DO   = do_q;
    assign drp.DRdy = drdy_q;

endmodule

// File: rtl/drp_adc_emulator.sv
// Single-channel ADC emulator: conversion FSM, optional 4-sample averager and a
// DRP register file. Optional feature macro: DRP_ADC_EMULATOR_AVERAGING_EN.
module drp_adc_emulator
    import drp_adc_pkg::*;
#(
    parameter int CONV_CYCLES = DEF_CONV_CYCLES,
    parameter int DRP_LAT     = DEF_DRP_LAT
) (
    input  logic               AdcClk,
    input  logic               AdcRstN,
    input  logic               ConvSt,
    input  logic [11:0]        SampleIn,
    drp_adc_emulator_if.slave  drp,
    output logic               Busy,
    output logic               Eoc,
    output logic               Eos
);

    // CONVERT lasts CONV_CYCLES-1 cycles: the counter is loaded with one less.
    localparam logic [15:0] CNT_INIT = (CONV_CYCLES > 2) ? 16'(CONV_CYCLES - 2) : 16'd0;

    conv_state_e state_q;
    logic [15:0] cnt_q;
    logic        busy_q;
    logic        eoc_q;
    logic        convst_prev_q;
    logic        start_s;
    logic        res_we_s;
    logic [15:0] res_data_s;
    logic [11:0] result12_s;

    // Start only on a ConvSt rising edge seen while idle; busy-time edges are lost.
    always_comb begin
        start_s    = ConvSt && !convst_prev_q && (state_q == ST_IDLE);
        res_we_s   = (state_q == ST_DONE);
        res_data_s = {result12_s, 4'b0000};
    end

    // ConvSt edge history.
    always_ff @(posedge AdcClk) begin
        if (!AdcRstN) begin
            convst_prev_q <= 1'b0;
        end else begin
            convst_prev_q <= ConvSt;
        end
    end

`ifdef DRP_ADC_EMULATOR_AVERAGING_EN
    logic [11:0] hist_q [4];

    // Four-deep sample history, newest in slot 0.
    always_ff @(posedge AdcClk) begin
        if (!AdcRstN) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= 12'h000;
            end
        end else if (start_s) begin
            hist_q[3] <= hist_q[2];
            hist_q[2] <= hist_q[1];
            hist_q[1] <= hist_q[0];
            hist_q[0] <= SampleIn;
        end
    end

    assign result12_s = avg4(hist_q[0], hist_q[1], hist_q[2], hist_q[3]);
`else
    logic [11:0] sample_q;

    // Sample captured on the accepted start edge.
    always_ff @(posedge AdcClk) begin
        if (!AdcRstN) begin
            sample_q <= 12'h000;
        end else if (start_s) begin
            sample_q <= SampleIn;
        end
    end

    assign result12_s = sample_q;
`endif

    // Conversion FSM with registered Busy/Eoc.
    always_ff @(posedge AdcClk) begin
        if (!AdcRstN) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            busy_q  <= 1'b0;
            eoc_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    eoc_q <= 1'b0;
                    if (start_s) begin
                        state_q <= ST_CONVERT;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        eoc_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    eoc_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 16'd0;
                    busy_q  <= 1'b0;
                    eoc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_q;
    assign Eoc  = eoc_q;
    assign Eos  = eoc_q;

    drp_adc_regfile #(
        .DRP_LAT (DRP_LAT)
    ) u_regfile (
        .AdcClk     (AdcClk),
        .AdcRstN    (AdcRstN),
        .drp        (drp),
        .res_we_i   (res_we_s),
        .res_data_i (res_data_s)
    );

endmodule

// File: tb/tb_drp_adc_emulator.sv
// Self-checking bench for drp_adc_emulator: directed scenarios plus randomized
// conversions and DRP traffic against a behavioural register/conversion model.
module tb_drp_adc_emulator;
    import drp_adc_pkg::*;

    localparam int CONV = DEF_CONV_CYCLES;
    localparam int LAT  = DEF_DRP_LAT;

    logic        AdcClk = 1'b0;
    logic        AdcRstN;
    logic        ConvSt;
    logic [11:0] SampleIn;
    logic        Busy;
    logic        Eoc;
    logic        Eos;

    drp_adc_emulator_if drp_if ();

    drp_adc_emulator #(
        .CONV_CYCLES (CONV),
        .DRP_LAT     (LAT)
    ) dut (
        .AdcClk   (AdcClk),
        .AdcRstN  (AdcRstN),
        .ConvSt   (ConvSt),
        .SampleIn (SampleIn),
        .drp      (drp_if),
        .Busy     (Busy),
        .Eoc      (Eoc),
        .Eos      (Eos)
    );

    always #5 AdcClk = ~AdcClk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: register contents, sample history, result awaiting Eoc.
    logic [15:0] m_result;
    logic [15:0] m_cfg [3];
    logic [11:0] m_hist [$];
    logic [15:0] m_pending;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge AdcClk);
        #1;
    endtask

    task automatic model_reset();
        m_result  = 16'h0000;
        m_pending = 16'h0000;
        for (int i = 0; i < 3; i++) m_cfg[i] = 16'h0000;
        m_hist = {12'h000, 12'h000, 12'h000, 12'h000};
    endtask

    task automatic model_start(input logic [11:0] s);
        int sum;
        m_hist.push_back(s);
        void'(m_hist.pop_front());
        sum = 0;
        foreach (m_hist[i]) sum += int'(m_hist[i]);
`ifdef DRP_ADC_EMULATOR_AVERAGING_EN
        m_pending = 16'(sum / 4) << 4;
`else
        m_pending = {s, 4'h0};
`endif
    endtask

    function automatic logic [15:0] model_read(input logic [6:0] a);
        if (a == 7'h00) return m_result;
        if (a >= 7'h40 && a <= 7'h42) return m_cfg[int'(a) - 64];
        return 16'h0000;
    endfunction

    // One DRP access starting in the current cycle; checks latency, data, pulse width.
    task automatic drp_access(input logic [6:0] a, input logic we, input logic [15:0] di,
                              output logic [15:0] got);
        logic [15:0] exp;
        int k;
        exp = we ? 16'h0000 : model_read(a);
        drp_if.DAddr = a;
        drp_if.DWe   = we;
        drp_if.DI    = di;
        drp_if.DEn   = 1'b1;
        step();
        drp_if.DEn = 1'b0;
        drp_if.DWe = 1'b0;
        if (we && a >= 7'h40 && a <= 7'h42) m_cfg[int'(a) - 64] = di;
        k = 1;
        while (drp_if.DRdy !== 1'b1 && k < 20) begin
            check("do_idle", drp_if.DO, 16'h0000);
            step();
            k++;
        end
        check("drp_latency", k, LAT);
        got = drp_if.DO;
        check("drp_do", got, exp);
        step();
        check("drdy_pulse", drp_if.DRdy, 1'b0);
    endtask

    // Full conversion from an idle FSM; checks Busy length, Eoc position, Eos==Eoc.
    task automatic conv(input logic [11:0] s);
        int busy_n, eoc_n, eoc_at, eos_bad;
        ConvSt   = 1'b1;
        SampleIn = s;
        step();
        ConvSt   = 1'b0;
        SampleIn = 12'($urandom);
        model_start(s);
        busy_n = 0; eoc_n = 0; eoc_at = 0; eos_bad = 0;
        for (int i = 1; i <= CONV + 4; i++) begin
            if (Busy === 1'b1) busy_n++;
            if (Eoc === 1'b1) begin
                eoc_n++;
                eoc_at = i;
            end
            if (Eos !== Eoc) eos_bad++;
            step();
        end
        m_result = m_pending;
        check("busy_cycles", busy_n, CONV - 1);
        check("eoc_count", eoc_n, 1);
        check("eoc_cycle", eoc_at, CONV);
        check("eos_eq_eoc", eos_bad, 0);
    endtask

    logic [15:0] got;
    int          k, n, eoc_n;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        AdcRstN = 1'b0;
        ConvSt = 1'b0;
        SampleIn = 12'h000;
        drp_if.DAddr = 7'h00;
        drp_if.DEn = 1'b0;
        drp_if.DWe = 1'b0;
        drp_if.DI = 16'h0000;
        model_reset();
        repeat (3) step();
        check("rst_busy", Busy, 1'b0);
        check("rst_eoc", Eoc, 1'b0);
        check("rst_eos", Eos, 1'b0);
        check("rst_drdy", drp_if.DRdy, 1'b0);
        check("rst_do", drp_if.DO, 16'h0000);
        AdcRstN = 1'b1;
        step();

        // Basic conversion and readback
        conv(12'hA5C);
        drp_access(7'h00, 1'b0, 16'h0000, got);
`ifndef DRP_ADC_EMULATOR_AVERAGING_EN
        check("a5c_read", got, 16'hA5C0);
`endif

        // Config write/read, write to read-only result, unmapped address
        drp_access(7'h41, 1'b1, 16'hBEEF, got);
        drp_access(7'h41, 1'b0, 16'h0000, got);
        check("cfg1_beef", got, 16'hBEEF);
        drp_access(7'h00, 1'b1, 16'hFFFF, got);
        drp_access(7'h00, 1'b0, 16'h0000, got);
        drp_access(7'h13, 1'b0, 16'h0000, got);
        check("unmapped_zero", got, 16'h0000);

        // DEn tied to Eoc: read in the DONE cycle returns the new result
        ConvSt = 1'b1;
        SampleIn = 12'h123;
        step();
        ConvSt = 1'b0;
        model_start(12'h123);
        k = 1;
        while (Eoc !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        check("bypass_eoc_cycle", k, CONV);
        m_result = m_pending;
        drp_access(7'h00, 1'b0, 16'h0000, got);
`ifndef DRP_ADC_EMULATOR_AVERAGING_EN
        check("bypass_read", got, 16'h1230);
`endif

        // ConvSt held high does not retrigger
        ConvSt = 1'b1;
        SampleIn = 12'h5A5;
        step();
        model_start(12'h5A5);
        eoc_n = 0;
        for (int i = 0; i < 100; i++) begin
            if (Eoc === 1'b1) eoc_n++;
            step();
        end
        ConvSt = 1'b0;
        step();
        m_result = m_pending;
        check("held_convst_eoc", eoc_n, 1);
        drp_access(7'h00, 1'b0, 16'h0000, got);

        // Second DEn while pending is dropped
        drp_access(7'h40, 1'b1, 16'h1357, got);
        drp_if.DAddr = 7'h40;
        drp_if.DEn = 1'b1;
        step();
        step();
        drp_if.DEn = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (drp_if.DRdy === 1'b1) begin
                n++;
                check("double_den_do", drp_if.DO, 16'h1357);
            end
            step();
        end
        check("double_den_drdy", n, 1);

        // Randomized conversions and DRP traffic
        for (int r = 0; r < 6; r++) begin
            conv(12'($urandom));
            for (int j = 0; j < 4; j++) begin
                logic [6:0] a;
                case ($urandom_range(0, 3))
                    0:       a = 7'h00;
                    1:       a = 7'h40 + 7'($urandom_range(0, 2));
                    2:       a = 7'($urandom);
                    default: a = ($urandom_range(0, 1) == 0) ? 7'h3F : 7'h43;
                endcase
                drp_access(a, 1'($urandom_range(0, 1)), 16'($urandom), got);
            end
        end

        // DRP traffic overlapping a conversion
        ConvSt = 1'b1;
        SampleIn = 12'h9C3;
        step();
        ConvSt = 1'b0;
        model_start(12'h9C3);
        drp_access(7'h00, 1'b0, 16'h0000, got);
        drp_access(7'h42, 1'b1, 16'h2468, got);
        drp_access(7'h42, 1'b0, 16'h0000, got);
        check("overlap_busy", Busy, 1'b1);
        k = 0;
        while (Eoc !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        check("overlap_eoc_seen", Eoc, 1'b1);
        step();
        m_result = m_pending;
        drp_access(7'h00, 1'b0, 16'h0000, got);

        // Reset at cycle 10 of a conversion with a read pending
        drp_access(7'h41, 1'b1, 16'hCAFE, got);
        ConvSt = 1'b1;
        SampleIn = 12'h777;
        step();
        ConvSt = 1'b0;
        repeat (8) step();
        drp_if.DAddr = 7'h41;
        drp_if.DEn = 1'b1;
        step();
        drp_if.DEn = 1'b0;
        AdcRstN = 1'b0;
        step();
        AdcRstN = 1'b1;
        model_reset();
        check("midrst_busy", Busy, 1'b0);
        check("midrst_drdy", drp_if.DRdy, 1'b0);
        check("midrst_do", drp_if.DO, 16'h0000);
        eoc_n = 0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (Eoc === 1'b1) eoc_n++;
            if (drp_if.DRdy === 1'b1) n++;
            step();
        end
        check("midrst_no_eoc", eoc_n, 0);
        check("midrst_no_drdy", n, 0);
        drp_access(7'h00, 1'b0, 16'h0000, got);
        check("midrst_result", got, 16'h0000);
        drp_access(7'h41, 1'b0, 16'h0000, got);
        check("midrst_cfg1", got, 16'h0000);

`ifdef DRP_ADC_EMULATOR_AVERAGING_EN
        conv(12'h100);
        drp_access(7'h00, 1'b0, 16'h0000, got);
        check("avg_1", got, 16'h0400);
        conv(12'h200);
        drp_access(7'h00, 1'b0, 16'h0000, got);
        check("avg_2", got, 16'h0C00);
        conv(12'h300);
        drp_access(7'h00, 1'b0, 16'h0000, got);
        check("avg_3", got, 16'h1800);
        conv(12'h400);
        drp_access(7'h00, 1'b0, 16'h0000, got);
        check("avg_4", got, 16'h2800);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
